// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit_if
//  Purpose  : Request/response bundle between the pipeline and the iterative
//             multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Start;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] Result;

  // Requester side: issues operations, watches Busy/Done/Result.
  modport master (
    output Start, Funct3, SrcA, SrcB,
    input  Busy, Done, Result
  );

  // Unit side: accepts operations, reports status and result.
  modport slave (
    input  Start, Funct3, SrcA, SrcB,
    output Busy, Done, Result
  );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative multiply / divide unit. Shift-add multiply and
//             restoring divide on operand magnitudes, one bit per cycle, with
//             sign correction applied when the result is written. Divide by
//             zero and signed overflow complete through a one-cycle fast path.
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mul_div_unit_if.slave  bus
);

  localparam int         c_W    = DATA_WIDTH;
  localparam logic [5:0] c_LAST = 6'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [2:0]       r_op;
  logic             r_neg_q;     // negate product / quotient at the end
  logic             r_neg_r;     // negate remainder at the end
  logic [5:0]       r_cnt;
  logic [2*c_W-1:0] r_x;         // mul: shifting multiplicand; div: dividend -> quotient (low half)
  logic [c_W-1:0]   r_y;         // mul: shifting multiplier;   div: divisor
  logic [2*c_W-1:0] r_acc;       // mul: partial product;       div: partial remainder (low half)
  logic [c_W-1:0]   r_result;

  logic             w_sign_a;
  logic             w_sign_b;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [c_W-1:0]   w_mag_a;
  logic [c_W-1:0]   w_mag_b;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_fast;
  logic [c_W-1:0]   w_fast_res;

  logic [c_W:0]     w_shift;
  logic             w_ge;
  logic [c_W-1:0]   w_sub;
  logic [2*c_W-1:0] w_x_nxt;
  logic [c_W-1:0]   w_y_nxt;
  logic [2*c_W-1:0] w_acc_nxt;

  logic [2*c_W-1:0] w_prod;
  logic [c_W-1:0]   w_q_mag;
  logic [c_W-1:0]   w_r_mag;
  logic [c_W-1:0]   w_quo;
  logic [c_W-1:0]   w_rem;
  logic [c_W-1:0]   w_final;

  // Operand decode: signedness per op, magnitudes and fast-path detection.
  always_comb begin
    w_sign_a   = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b010) ||
                 (bus.Funct3 == 3'b100) || (bus.Funct3 == 3'b110);
    w_sign_b   = (bus.Funct3 == 3'b001) || (bus.Funct3 == 3'b100) ||
                 (bus.Funct3 == 3'b110);
    w_neg_a    = w_sign_a & bus.SrcA[c_W-1];
    w_neg_b    = w_sign_b & bus.SrcB[c_W-1];
    w_mag_a    = w_neg_a ? (~bus.SrcA + 1'b1) : bus.SrcA;
    w_mag_b    = w_neg_b ? (~bus.SrcB + 1'b1) : bus.SrcB;
    w_div_zero = bus.Funct3[2] && (bus.SrcB == '0);
    w_ovf      = bus.Funct3[2] && !bus.Funct3[0] &&
                 (bus.SrcA == {1'b1, {(c_W-1){1'b0}}}) && (bus.SrcB == '1);
    w_fast     = w_div_zero || w_ovf;
    w_fast_res = '0;
    if (w_div_zero) begin
      w_fast_res = bus.Funct3[1] ? bus.SrcA : '1;
    end else if (w_ovf) begin
      w_fast_res = bus.Funct3[1] ? '0 : bus.SrcA;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    w_shift   = {r_acc[c_W-1:0], r_x[c_W-1]};
    w_ge      = (w_shift >= {1'b0, r_y});
    w_sub     = w_shift[c_W-1:0] - r_y;
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_acc_nxt = r_acc;
    if (!r_op[2]) begin
      w_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;
      w_x_nxt   = r_x << 1;
      w_y_nxt   = r_y >> 1;
    end else begin
      w_acc_nxt = {{c_W{1'b0}}, (w_ge ? w_sub : w_shift[c_W-1:0])};
      w_x_nxt   = {{c_W{1'b0}}, r_x[c_W-2:0], w_ge};
    end
  end

  // Sign correction and result selection for the final iteration.
  always_comb begin
    w_prod  = r_neg_q ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    w_q_mag = w_x_nxt[c_W-1:0];
    w_r_mag = w_acc_nxt[c_W-1:0];
    w_quo   = r_neg_q ? (~w_q_mag + 1'b1) : w_q_mag;
    w_rem   = r_neg_r ? (~w_r_mag + 1'b1) : w_r_mag;
    case (r_op)
      3'b000:                   w_final = w_prod[c_W-1:0];
      3'b001, 3'b010, 3'b011:   w_final = w_prod[2*c_W-1:c_W];
      3'b100, 3'b101:           w_final = w_quo;
      default:                  w_final = w_rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_state_nxt = w_fast ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration registers, counter and result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_op    <= bus.Funct3;
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_cnt   <= '0;
            r_x     <= {{c_W{1'b0}}, w_mag_a};
            r_y     <= w_mag_b;
            r_acc   <= '0;
            if (w_fast) begin
              r_result <= w_fast_res;
            end
          end
        end
        S_CALC: begin
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == c_LAST) begin
            r_result <= w_final;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.Busy   = (r_state != S_IDLE);
  assign bus.Done   = (r_state == S_DONE);
  assign bus.Result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Directed self-checking bench for mul_div_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_div_unit_if #(.DATA_WIDTH(32)) bus ();

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Issue one op (Start sampled at edge N), scramble inputs afterwards, and
  // measure the cycle (N+lat) in which Done appears. ok is cleared if Busy is
  // low or Result moves before Done, or if the following cycle is not idle.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output bit ok);
    logic [31:0] prev;
    ok = 1'b1;
    @(negedge clk);
    prev       = bus.Result;
    bus.Start  = 1'b1;
    bus.Funct3 = f;
    bus.SrcA   = a;
    bus.SrcB   = b;
    @(posedge clk);
    #1;
    bus.Start  = 1'b0;
    bus.Funct3 = ~f;
    bus.SrcA   = ~a;
    bus.SrcB   = b ^ 32'h5A5A_A5A5;
    lat = 1;
    while (bus.Done !== 1'b1 && lat < 40) begin
      if (bus.Busy !== 1'b1 || bus.Result !== prev) ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.Result;
    if (bus.Busy !== 1'b1) ok = 1'b0;
    @(posedge clk);
    #1;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== res) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000",
               bus.Busy, bus.Done, bus.Result);
    end
    bus.Start = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_priority: busy=%b, required 0", bus.Busy);
    end
  endtask

  task automatic test_mul();
    vec_t tbl[$];
    int lat; logic [31:0] res; bit ok;
    tbl.push_back('{"MUL 7x-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33});
    tbl.push_back('{"MULHU -1x-1",   3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
    tbl.push_back('{"MULH -1x-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
    tbl.push_back('{"MULHSU -1x2",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33});
    tbl.push_back('{"MUL 12345x678", 3'b000, 32'd12345,    32'd678,      32'd8369910,  33});
    foreach (tbl[i]) begin
      do_op(tbl[i].f, tbl[i].a, tbl[i].b, lat, res, ok);
      n_checks++;
      if (res !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", tbl[i].name, res, tbl[i].exp);
      end
      n_checks++;
      if (lat != tbl[i].lat || !ok) begin
        n_fail++;
        $display("FAIL %s timing: done at N+%0d handshake_ok=%0d, required N+%0d ok=1",
                 tbl[i].name, lat, ok, tbl[i].lat);
      end
    end
  endtask

  task automatic test_div();
    vec_t tbl[$];
    int lat; logic [31:0] res; bit ok;
    tbl.push_back('{"DIV -7/2",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33});
    tbl.push_back('{"REM -7/2",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33});
    tbl.push_back('{"DIVU 100/7", 3'b101, 32'd100,      32'd7,        32'd14,       33});
    tbl.push_back('{"REMU 100/7", 3'b111, 32'd100,      32'd7,        32'd2,        33});
    tbl.push_back('{"DIV 20/-3",  3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 33});
    tbl.push_back('{"REM 20/-3",  3'b110, 32'd20,       32'hFFFFFFFD, 32'd2,        33});
    foreach (tbl[i]) begin
      do_op(tbl[i].f, tbl[i].a, tbl[i].b, lat, res, ok);
      n_checks++;
      if (res !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", tbl[i].name, res, tbl[i].exp);
      end
      n_checks++;
      if (lat != tbl[i].lat || !ok) begin
        n_fail++;
        $display("FAIL %s timing: done at N+%0d handshake_ok=%0d, required N+%0d ok=1",
                 tbl[i].name, lat, ok, tbl[i].lat);
      end
    end
  endtask

  task automatic test_fast_path();
    vec_t tbl[$];
    int lat; logic [31:0] res; bit ok;
    tbl.push_back('{"DIVU 5/0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    tbl.push_back('{"REMU 5/0",    3'b111, 32'd5,        32'd0,        32'd5,        1});
    tbl.push_back('{"DIV -9/0",    3'b100, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFFF, 1});
    tbl.push_back('{"REM -9/0",    3'b110, 32'hFFFFFFF7, 32'd0,        32'hFFFFFFF7, 1});
    tbl.push_back('{"DIV ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    tbl.push_back('{"REM ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});
    tbl.push_back('{"DIVU min/-1", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33});
    foreach (tbl[i]) begin
      do_op(tbl[i].f, tbl[i].a, tbl[i].b, lat, res, ok);
      n_checks++;
      if (res !== tbl[i].exp) begin
        n_fail++;
        $display("FAIL %s result: got %h, required %h", tbl[i].name, res, tbl[i].exp);
      end
      n_checks++;
      if (lat != tbl[i].lat || !ok) begin
        n_fail++;
        $display("FAIL %s timing: done at N+%0d handshake_ok=%0d, required N+%0d ok=1",
                 tbl[i].name, lat, ok, tbl[i].lat);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra_done;
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd4;
    @(posedge clk);                     // edge N
    #1;
    bus.Start = 1'b0;
    lat = 1;
    while (bus.Done !== 1'b1 && lat < 40) begin
      if (lat == 5) begin                // sampled at edge N+5
        bus.Start  = 1'b1;
        bus.Funct3 = 3'b100;
        bus.SrcA   = 32'd9;
        bus.SrcB   = 32'd3;
      end else begin
        bus.Start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.Start = 1'b0;
    n_checks++;
    if (lat != 33 || bus.Result !== 32'd12) begin
      n_fail++;
      $display("FAIL ignore_start: done at N+%0d result=%h, required N+33 0000000c",
               lat, bus.Result);
    end
    extra_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) extra_done++;
    end
    n_checks++;
    if (extra_done != 0 || bus.Result !== 32'd12) begin
      n_fail++;
      $display("FAIL no_second_op: extra busy/done cycles=%0d result=%h, required 0 0000000c",
               extra_done, bus.Result);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat; logic [31:0] res; bit ok;
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Funct3 = 3'b000;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd4;
    @(posedge clk);                     // edge N
    #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);          // edge N+9
    #1;
    reset = 1'b1;
    @(posedge clk);                     // edge N+10
    #1;
    reset = 1'b0;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.Result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_calc: busy=%b done=%b result=%h, required 0 0 00000000",
               bus.Busy, bus.Done, bus.Result);
    end
    do_op(3'b000, 32'd6, 32'd7, lat, res, ok);
    n_checks++;
    if (res !== 32'd42 || lat != 33 || !ok) begin
      n_fail++;
      $display("FAIL after_reset_mul: result=%h lat=N+%0d ok=%0d, required 0000002a N+33 1",
               res, lat, ok);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_ignore_start();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
